keypad_scanner: RTL
===================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 12000, meaning hwclk cycles each row is driven (1 ms at 12 MHz).
REQ-002 SHALL have parameter DEBOUNCE_FRAMES, default 8, meaning consecutive identical full-scan results required to accept a change.
REQ-003 SHALL have parameter REPEAT_FRAMES, default 150, meaning frames between auto-repeat strobes (used only with KEYPAD_REPEAT_EN).
REQ-004 SHALL have port hwclk, input, 1, the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have ports keypad_r1/r2/r3, output, 1 each, row drives; the active row is low, all other rows are high.
REQ-007 SHALL have ports keypad_c1/c2/c3, input, 1 each, asynchronous column sense, pulled up; low means pressed.
REQ-008 SHALL have port button, output, 4, accepted key code.
REQ-009 SHALL have port bstate, output, 1, one-cycle strobe qualifying button.
REQ-010 SHALL have port held, output, 1, level; high while the accepted key remains down.

Function
REQ-011 Each column SHALL pass through a two-flop synchronizer before use.
REQ-012 Rows SHALL be driven in the order r1, r2, r3, r1, ..., each for exactly SCAN_DIV cycles; one pass is a frame of 3*SCAN_DIV cycles.
REQ-013 Synchronized columns SHALL be sampled into a 9-bit frame image on the last cycle of each row dwell.
REQ-014 At frame end, the image SHALL reduce to a frame code: no bits set gives 0; exactly one bit at row r, column c (both 0-based) gives r*3+c+1 (values 1..9); two or more bits set gives 15 (MULTI).
REQ-015 Debounce: if the frame code equals the candidate, the stable count SHALL increment, saturating at DEBOUNCE_FRAMES; otherwise the candidate SHALL take the new code and the count SHALL become 1.
REQ-016 The candidate SHALL be accepted when the count reaches DEBOUNCE_FRAMES; a MULTI candidate SHALL never be accepted, and the state is held.
REQ-017 FSM states: IDLE (accepted 0) and HELD (accepted key K).
REQ-018 In IDLE, accepting K in 1..9 SHALL set button=K, pulse bstate for exactly one cycle, set held=1, and move to HELD.
REQ-019 In HELD, accepting 0 SHALL clear held, keep button unchanged, emit no strobe, and move to IDLE.
REQ-020 In HELD, accepting a different key K' SHALL cause no strobe and no change to button; a new press requires a release through IDLE.
REQ-021 bstate SHALL assert on the cycle after the frame-end cycle on which acceptance occurs.
REQ-022 bstate SHALL never be high on two consecutive cycles.

Reset
REQ-023 While reset is high, the block SHALL force: button=0, bstate=0, held=0, FSM=IDLE, candidate=0, count=0, frame image cleared, row index=r1, dwell counter=0, and synchronizers cleared to the released state (1).
REQ-024 A reset asserted mid-frame or during HELD SHALL discard all partial state; no strobe is generated by reset or its release.

Configuration
REQ-025 Macro KEYPAD_REPEAT_EN defined: in HELD, after REPEAT_FRAMES further frames with the accepted key still the frame code, bstate SHALL re-pulse with the same button value, repeating every REPEAT_FRAMES frames; the counter SHALL clear on leaving HELD.
REQ-026 Macro KEYPAD_REPEAT_EN undefined: no repeat logic is present, and exactly one strobe is produced per press.

Structure
REQ-027 Package keypad_pkg SHALL hold NUM_ROWS=3, NUM_COLS=3, KEY_NONE=4'd0, KEY_MULTI=4'd15, the FSM state typedef, and the key-code width.
REQ-028 Sub-module keypad_debounce SHALL contain the candidate/count logic (REQ-015 and REQ-016), with inputs frame_code and frame_done and outputs accepted_code and accept.

Verification (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame=12 cycles)
REQ-029 Hold c2 low while r2 is active for 5 frames -> exactly one bstate with button=5, asserted 1 cycle after the 3rd frame end; held=1.
REQ-030 Press key 5, then bounce c2 high for 1 frame in every 2 -> no strobe until 3 consecutive stable frames are seen; exactly one strobe is produced.
REQ-031 Hold keys 1 and 9 together for 6 frames -> no strobe, held=0; then release 9 -> strobe with button=1 after 3 frames.
REQ-032 Hold 4, then switch to 6 without releasing -> no second strobe and button stays 4; release for 3 frames, then press 6 -> strobe with button=6.
REQ-033 Assert reset for 1 cycle during frame 2 of a press of 7 -> outputs zero and r1 is driven next cycle; the key is re-detected 3 full frames after reset.
REQ-034 With KEYPAD_REPEAT_EN and REPEAT_FRAMES=2, hold 3 for 9 frames -> strobes at frames 3, 5, 7 and 9, each with button=3.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, constants and the frame-image reduction for the 3x3 keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 3;
    localparam int NUM_COLS = 3;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
    localparam int KEY_W    = 4;

    localparam logic [KEY_W-1:0] KEY_NONE  = 4'd0;
    localparam logic [KEY_W-1:0] KEY_MULTI = 4'd15;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } key_state_t;

    // Bit r*NUM_COLS+c of the image is key r*NUM_COLS+c+1; any two bits collapse to MULTI.
    function automatic logic [KEY_W-1:0] image_to_code(input logic [NUM_KEYS-1:0] img);
        logic [KEY_W-1:0] code;
        int               hits;
        code = KEY_NONE;
        hits = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (img[i]) begin
                hits = hits + 1;
                code = KEY_W'(i + 1);
            end
        end
        if (hits > 1) code = KEY_MULTI;
        return code;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate debouncer: a frame code must repeat DEBOUNCE_FRAMES times in a row to be accepted.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 8
) (
    input  logic             hwclk,
    input  logic             reset,
    input  logic             frame_done,
    input  logic [KEY_W-1:0] frame_code,
    output logic [KEY_W-1:0] accepted_code,
    output logic             accept
);

    localparam int               CW      = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(DEBOUNCE_FRAMES);

    logic [KEY_W-1:0] candidate;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_n;

    always_comb begin
        count_n = CW'(1);
        if (frame_code == candidate) begin
            count_n = (count == CNT_MAX) ? count : count + CW'(1);
        end
    end

    // Accept stays asserted on every stable frame once saturated; the FSM treats repeats idempotently.
    assign accept        = frame_done && (count_n == CNT_MAX) && (frame_code != KEY_MULTI);
    assign accepted_code = frame_code;

    always_ff @(posedge hwclk) begin
        if (reset) begin
            candidate <= KEY_NONE;
            count     <= '0;
        end else if (frame_done) begin
            candidate <= frame_code;
            count     <= count_n;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 3x3 row-scanned keypad with debounce and press strobe; define KEYPAD_REPEAT_EN for auto-repeat.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 12000,
    parameter int DEBOUNCE_FRAMES = 8,
    parameter int REPEAT_FRAMES   = 150
) (
    input  logic             hwclk,
    input  logic             reset,
    output logic             keypad_r1,
    output logic             keypad_r2,
    output logic             keypad_r3,
    input  logic             keypad_c1,
    input  logic             keypad_c2,
    input  logic             keypad_c3,
    output logic [KEY_W-1:0] button,
    output logic             bstate,
    output logic             held,
    output key_state_t       fsm_state
);

    localparam int            DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    // The two-flop synchronizer lags by two cycles, so a dwell shorter than 3 samples the previous row.
    if (SCAN_DIV < 3 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_param_range_invalid
    end

    logic [NUM_COLS-1:0] col_meta;
    logic [NUM_COLS-1:0] col_sync;
    logic [DW-1:0]       div_cnt;
    logic [1:0]          row_idx;
    logic [NUM_KEYS-1:0] image;
    logic [NUM_KEYS-1:0] frame_img;
    logic                dwell_end;
    logic                frame_done;
    logic [KEY_W-1:0]    frame_code;
    logic [KEY_W-1:0]    accepted_code;
    logic                accept;
    key_state_t          state;
    key_state_t          state_n;
    logic [KEY_W-1:0]    button_n;
    logic                bstate_n;

    always_ff @(posedge hwclk) begin
        if (reset) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= {keypad_c3, keypad_c2, keypad_c1};
            col_sync <= col_meta;
        end
    end

    assign dwell_end  = (div_cnt == DIV_LAST);
    assign frame_done = dwell_end && (row_idx == 2'(NUM_ROWS - 1));

    // Image with the active row's pressed bits merged in, so frame end sees row 3 immediately.
    always_comb begin
        frame_img = image;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (row_idx == 2'(r)) frame_img[r*NUM_COLS +: NUM_COLS] = ~col_sync;
        end
    end

    assign frame_code = image_to_code(frame_img);

    always_ff @(posedge hwclk) begin
        if (reset) begin
            div_cnt <= '0;
            row_idx <= 2'd0;
            image   <= '0;
        end else if (dwell_end) begin
            div_cnt <= '0;
            row_idx <= frame_done ? 2'd0 : row_idx + 2'd1;
            image   <= frame_img;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign keypad_r1 = (row_idx != 2'd0);
    assign keypad_r2 = (row_idx != 2'd1);
    assign keypad_r3 = (row_idx != 2'd2);

    keypad_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .hwclk        (hwclk),
        .reset        (reset),
        .frame_done   (frame_done),
        .frame_code   (frame_code),
        .accepted_code(accepted_code),
        .accept       (accept)
    );

`ifdef KEYPAD_REPEAT_EN
    localparam int            RW       = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_FRAMES - 1);
    logic [RW-1:0] rep_cnt;
    logic [RW-1:0] rep_cnt_n;
`endif

    always_comb begin
        state_n  = state;
        button_n = button;
        bstate_n = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_cnt_n = rep_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (accept && accepted_code != KEY_NONE) begin
                    state_n  = ST_HELD;
                    button_n = accepted_code;
                    bstate_n = 1'b1;
                end
            end
            ST_HELD: begin
                // A different key accepted while held is ignored until a release returns to IDLE.
                if (accept && accepted_code == KEY_NONE) begin
                    state_n = ST_IDLE;
`ifdef KEYPAD_REPEAT_EN
                    rep_cnt_n = '0;
`endif
                end
`ifdef KEYPAD_REPEAT_EN
                else if (frame_done) begin
                    if (frame_code != button) begin
                        rep_cnt_n = '0;
                    end else if (rep_cnt == REP_LAST) begin
                        rep_cnt_n = '0;
                        bstate_n  = 1'b1;
                    end else begin
                        rep_cnt_n = rep_cnt + RW'(1);
                    end
                end
`endif
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge hwclk) begin
        if (reset) begin
            state  <= ST_IDLE;
            button <= KEY_NONE;
            bstate <= 1'b0;
            held   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt <= '0;
`endif
        end else begin
            state  <= state_n;
            button <= button_n;
            bstate <= bstate_n;
            held   <= (state_n == ST_HELD);
`ifdef KEYPAD_REPEAT_EN
            rep_cnt <= rep_cnt_n;
`endif
        end
    end

    assign fsm_state = state;

endmodule
